// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC rotation unit.
// Latency: n/a (types, constants and a table lookup only).
// Backpressure: n/a.
// Contents: WIDTH/DATA_W sizing, fixed_t datapath word, FSM state enum,
//           arctangent table (round(atan(2^-i) * 2^24)) and its lookup helper.
package cordic_pkg;

  localparam int WIDTH  = 24;
  localparam int DATA_W = WIDTH + 2;
  localparam int ITER_W = 5;

  typedef logic signed [DATA_W-1:0] fixed_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Constant table instead of a memory file so every tool sees identical data.
  // From i=8 upward atan(2^-i) rounds to 2^(24-i); from i=25 it rounds to zero.
  localparam fixed_t ATAN_LUT [0:31] = '{
    26'h0C90FDB, 26'h076B19C, 26'h03EB6EC, 26'h01FD5BB,
    26'h00FFAAE, 26'h007FF55, 26'h003FFEB, 26'h001FFFD,
    26'h0010000, 26'h0008000, 26'h0004000, 26'h0002000,
    26'h0001000, 26'h0000800, 26'h0000400, 26'h0000200,
    26'h0000100, 26'h0000080, 26'h0000040, 26'h0000020,
    26'h0000010, 26'h0000008, 26'h0000004, 26'h0000002,
    26'h0000001, 26'h0000000, 26'h0000000, 26'h0000000,
    26'h0000000, 26'h0000000, 26'h0000000, 26'h0000000
  };

  function automatic fixed_t atan_at(input logic [ITER_W-1:0] idx);
    return ATAN_LUT[idx];
  endfunction

endpackage

// File: rtl/cordic_iter_sequencer_if.sv
// Handshake bundle between angle producer, CORDIC sequencer and result consumer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the angle side, out_valid/out_ready on the result side.
// Ports: in_valid/in_ready/in_angle (request), out_valid/out_ready/out_cos/out_sin/out_theta
//        (result), busy (status). slave = sequencer view, master = producer/consumer view.
interface cordic_iter_sequencer_if;
  import cordic_pkg::*;

  logic   in_valid;
  logic   in_ready;
  fixed_t in_angle;
  logic   out_valid;
  logic   out_ready;
  fixed_t out_cos;
  fixed_t out_sin;
  fixed_t out_theta;
  logic   busy;

  modport slave (
    input  in_valid, in_angle, out_ready,
    output in_ready, out_valid, out_cos, out_sin, out_theta, busy
  );

  modport master (
    output in_valid, in_angle, out_ready,
    input  in_ready, out_valid, out_cos, out_sin, out_theta, busy
  );
endinterface

// File: rtl/cordic_step.sv
// One CORDIC micro-rotation: rotate (x,y) by +/-atan(2^-shift), steered by the sign of w.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its inputs).
// Ports: shift = iteration index, atan = table value for that index,
//        x_i/y_i/w_i = current vector and residual angle, x_o/y_o/w_o = next values.
module cordic_step
  import cordic_pkg::*;
(
  input  logic [ITER_W-1:0] shift,
  input  fixed_t            atan,
  input  fixed_t            x_i,
  input  fixed_t            y_i,
  input  fixed_t            w_i,
  output fixed_t            x_o,
  output fixed_t            y_o,
  output fixed_t            w_o
);

  fixed_t x_sh;
  fixed_t y_sh;

  // fixed_t is signed, so >>> keeps the sign; add/sub wrap at DATA_W bits.
  always_comb begin
    x_sh = x_i >>> shift;
    y_sh = y_i >>> shift;
    if (!w_i[DATA_W-1]) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      w_o = w_i - atan;
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      w_o = w_i + atan;
    end
  end

endmodule

// File: rtl/cordic_iter_sequencer.sv
// Time-multiplexed CORDIC rotation: one micro-rotation stage reused for ITERS cycles.
// Latency: angle accepted on edge t -> out_valid after edge t+ITERS; one result per ITERS+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, reset_n (async active-low), io (slave modport: angle in, cos/sin/residual out, busy).
module cordic_iter_sequencer
  import cordic_pkg::*;
#(
  parameter int     ITERS  = 19,
  parameter fixed_t K_INIT = 26'h09B74EE
) (
  input  logic                     clk,
  input  logic                     reset_n,
  cordic_iter_sequencer_if.slave   io
);

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERS - 1);

  state_e            state_q, state_d;
  fixed_t            x_q, x_d;
  fixed_t            y_q, y_d;
  fixed_t            w_q, w_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  fixed_t            step_x;
  fixed_t            step_y;
  fixed_t            step_w;

  logic              in_ready;
  logic              out_valid;
  logic              busy;

  cordic_step u_step (
    .shift (iter_q),
    .atan  (atan_at(iter_q)),
    .x_i   (x_q),
    .y_i   (y_q),
    .w_i   (w_q),
    .x_o   (step_x),
    .y_o   (step_y),
    .w_o   (step_w)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    iter_d    = iter_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (io.in_valid) begin
          x_d     = K_INIT;
          y_d     = '0;
          w_d     = io.in_angle;
          iter_d  = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        busy   = 1'b1;
        x_d    = step_x;
        y_d    = step_y;
        w_d    = step_w;
        // Wraps to 0 after the last stage when ITERS is 32; harmless since
        // the counter is reloaded on the next accept.
        iter_d = iter_q + 1'b1;
        if (iter_q == LAST_ITER) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (io.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      iter_q  <= iter_d;
    end
  end

  // Result registers drive the outputs directly; they move during RUN.
  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.busy      = busy;
  assign io.out_cos   = x_q;
  assign io.out_sin   = y_q;
  assign io.out_theta = w_q;

endmodule

// File: doc/cordic_iter_sequencer.md
Name: cordic_iter_sequencer

Overview:
Time-multiplexed CORDIC rotation unit. One combinational micro-rotation stage is reused for ITERS clock cycles, replacing the 19-stage unrolled chain where area matters more than throughput. Accepts a fixed-point angle (output of the unpacker) over a valid/ready handshake and returns fixed-point cos/sin plus residual angle. Result feeds the packer.

Parameters:
WIDTH, 24, fractional bits; internal datapath is WIDTH+2 bits two's complement
ITERS, 19, micro-rotations per operation; legal range 1..32
K_INIT, 26'h9b74ee, initial x (CORDIC gain 0.607253 * 2^WIDTH)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  angle present
in_ready  out  1  block can accept angle
in_angle  in  WIDTH+2  fixed-point angle, radians * 2^WIDTH, legal range [-pi/2, +pi/2]
out_valid  out  1  result present
out_ready  in  1  consumer takes result
out_cos  out  WIDTH+2  final x
out_sin  out  WIDTH+2  final y
out_theta  out  WIDTH+2  residual angle w (debug/convergence check)
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (reset_n low, async): state=IDLE, x/y/w/iter=0, out_valid=0, busy=0, in_ready=1 once state is IDLE. Out_cos/out_sin/out_theta read 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On edge with in_valid: x<=K_INIT, y<=0, w<=in_angle, iter<=0, go RUN.
- RUN: in_ready=0. Each edge applies one stage with shift i=iter. If w>=0: x<=x-(y>>>i), y<=y+(x>>>i), w<=w-ATAN[i]. Else: x<=x+(y>>>i), y<=y-(x>>>i), w<=w+ATAN[i]. iter<=iter+1. Apply stage with iter==ITERS-1, then go DONE.
- Shifts are arithmetic. Add/sub wraps modulo 2^(WIDTH+2); no saturation.
- DONE: out_valid=1. Outputs hold x/y/w stable until handshake. On edge with out_ready go IDLE, out_valid drops next cycle.
- Latency: angle accepted on edge t -> out_valid high after edge t+ITERS. Throughput: one result per ITERS+2 cycles minimum (accept, ITERS iterations, drain).
- in_valid during RUN/DONE is ignored and not consumed. Producer holds its data until in_ready.
- out_ready in IDLE/RUN has no effect.
- Angle outside [-pi/2, pi/2]: no error flag. Result numerically wrong, but FSM still completes in ITERS cycles with no lockup.
- Reset asserted mid-RUN or mid-DONE: immediate abort to reset values. The pending result is lost.
- out_cos/out_sin/out_theta are driven directly from x/y/w registers. They change during RUN and are only meaningful while out_valid=1.

Decomposition:
- Package cordic_pkg:
  - DATA_W = WIDTH+2 typedef (fixed_t).
  - State enum.
  - ATAN_LUT[0:31] constant = round(atan(2^-i) * 2^24). ATAN_LUT[0]=26'hC90FDB, ATAN_LUT[1]=26'h76B19C.
  - The table is a package constant, not $readmemh, so simulation and synthesis agree.
- Sub-module cordic_step: purely combinational single micro-rotation.
  - Inputs: shift i, atan, x, y, w.
  - Outputs: x', y', w'.
- Sequencer holds FSM, iteration counter (5 bits), and x/y/w registers.

Test Plan:
- Angle 0 -> out_cos within 0x1000000 +/-16 LSB, out_sin within 0 +/-16 LSB. out_valid rises exactly 19 edges after accept edge.
- Angle pi/3 (26'h10C1524) -> out_cos = 0x800000 +/-16, out_sin = 0xDDB3D7 +/-16, out_theta magnitude < 2^-17 * 2^24.
- Angle -pi/4 (two's complement of 26'hC90FDB) -> out_cos = 0xB504F3 +/-16, out_sin = -0xB504F3 +/-16.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid: outputs and out_valid stay constant, in_ready stays 0.
  - in_valid pulsed with a new angle during this time is not accepted.
  - Raise out_ready: IDLE next cycle.
- Back-to-back: in_valid held high with angles 0 then pi/3, out_ready tied 1 -> two correct results. Second accept occurs the edge after the first DONE handshake, ITERS+2 cycles apart.
- reset_n pulsed low asynchronously (mid-cycle) during iteration 7:
  - out_valid=0, busy=0 and in_ready=1 without waiting for a clock edge.
  - A following angle 0 produces a correct result with normal latency.
